// File: rtl/alu_issue_stage_if.sv
// ID->EX handshake bundle for the ALU issue stage: instruction and operands in,
// decoded ALU select and operands out, with valid/ready flow control on both sides.
interface alu_issue_stage_if #(
    parameter int XLEN = 32
);
    logic            id_valid;
    logic            id_ready;
    logic [31:0]     id_instr;
    logic [XLEN-1:0] id_rs_val;
    logic [XLEN-1:0] id_rt_val;
    logic            flush;
    logic            ex_ready;
    logic            ex_valid;
    logic [11:0]     ex_alu_f;
    logic [XLEN-1:0] ex_alu_a;
    logic [XLEN-1:0] ex_alu_b;
    logic            ex_br_neg;
    logic            ex_illegal;

    // Master is the surrounding pipeline (ID producer plus EX consumer).
    modport master (
        output id_valid, id_instr, id_rs_val, id_rt_val, flush, ex_ready,
        input  id_ready, ex_valid, ex_alu_f, ex_alu_a, ex_alu_b, ex_br_neg, ex_illegal
    );

    modport slave (
        input  id_valid, id_instr, id_rs_val, id_rt_val, flush, ex_ready,
        output id_ready, ex_valid, ex_alu_f, ex_alu_a, ex_alu_b, ex_br_neg, ex_illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// ID->EX stage: decodes MIPS-I integer instructions into a one-hot ALU select plus
// operands a/b and registers them behind a valid/ready handshake with flush.
module alu_issue_stage #(
    parameter int XLEN      = 32,
    parameter int LUI_SHIFT = 16
) (
    input  logic              clk,
    input  logic              rst,
    alu_issue_stage_if.slave  bus
);
    localparam logic [11:0] F_ADD  = 12'h001;
    localparam logic [11:0] F_SUB  = 12'h002;
    localparam logic [11:0] F_SLT  = 12'h004;
    localparam logic [11:0] F_SLTU = 12'h008;
    localparam logic [11:0] F_AND  = 12'h010;
    localparam logic [11:0] F_OR   = 12'h020;
    localparam logic [11:0] F_NOR  = 12'h040;
    localparam logic [11:0] F_XOR  = 12'h080;
    localparam logic [11:0] F_SLL  = 12'h100;
    localparam logic [11:0] F_SRL  = 12'h200;
    localparam logic [11:0] F_SRA  = 12'h400;
    localparam logic [11:0] F_EQ   = 12'h800;

    logic [5:0]      op;
    logic [5:0]      funct;
    logic [4:0]      shamt;
    logic [15:0]     imm;
    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;
    logic [XLEN-1:0] sx;
    logic [XLEN-1:0] zx;
    logic [XLEN-1:0] shamt_zx;

    assign op       = bus.id_instr[31:26];
    assign funct    = bus.id_instr[5:0];
    assign shamt    = bus.id_instr[10:6];
    assign imm      = bus.id_instr[15:0];
    assign rs_val   = bus.id_rs_val;
    assign rt_val   = bus.id_rt_val;
    assign sx       = {{(XLEN-16){imm[15]}}, imm};
    assign zx       = {{(XLEN-16){1'b0}}, imm};
    assign shamt_zx = {{(XLEN-5){1'b0}}, shamt};

    logic [11:0]     dec_f;
    logic [XLEN-1:0] dec_a;
    logic [XLEN-1:0] dec_b;
    logic            dec_br_neg;
    logic            dec_illegal;

    always_comb begin
        // NOTE: every decode output is defaulted before the case so no path can infer a latch.
        dec_f       = '0;
        dec_a       = '0;
        dec_b       = '0;
        dec_br_neg  = 1'b0;
        dec_illegal = 1'b0;
        case (op)
            6'h00: begin
                case (funct)
                    6'h20, 6'h21: begin dec_f = F_ADD;  dec_a = rs_val; dec_b = rt_val; end
                    6'h22, 6'h23: begin dec_f = F_SUB;  dec_a = rs_val; dec_b = rt_val; end
                    6'h2A:        begin dec_f = F_SLT;  dec_a = rs_val; dec_b = rt_val; end
                    6'h2B:        begin dec_f = F_SLTU; dec_a = rs_val; dec_b = rt_val; end
                    6'h24:        begin dec_f = F_AND;  dec_a = rs_val; dec_b = rt_val; end
                    6'h25:        begin dec_f = F_OR;   dec_a = rs_val; dec_b = rt_val; end
                    6'h27:        begin dec_f = F_NOR;  dec_a = rs_val; dec_b = rt_val; end
                    6'h26:        begin dec_f = F_XOR;  dec_a = rs_val; dec_b = rt_val; end
                    // Shifts take the value from rt; amount is shamt or rs (variable form).
                    6'h00:        begin dec_f = F_SLL;  dec_a = rt_val; dec_b = shamt_zx; end
                    6'h02:        begin dec_f = F_SRL;  dec_a = rt_val; dec_b = shamt_zx; end
                    6'h03:        begin dec_f = F_SRA;  dec_a = rt_val; dec_b = shamt_zx; end
                    6'h04:        begin dec_f = F_SLL;  dec_a = rt_val; dec_b = rs_val;   end
                    6'h06:        begin dec_f = F_SRL;  dec_a = rt_val; dec_b = rs_val;   end
                    6'h07:        begin dec_f = F_SRA;  dec_a = rt_val; dec_b = rs_val;   end
                    default:      dec_illegal = 1'b1;
                endcase
            end
            6'h08, 6'h09: begin dec_f = F_ADD;  dec_a = rs_val; dec_b = sx; end
            6'h0A:        begin dec_f = F_SLT;  dec_a = rs_val; dec_b = sx; end
            6'h0B:        begin dec_f = F_SLTU; dec_a = rs_val; dec_b = sx; end
            6'h0C:        begin dec_f = F_AND;  dec_a = rs_val; dec_b = zx; end
            6'h0D:        begin dec_f = F_OR;   dec_a = rs_val; dec_b = zx; end
            6'h0E:        begin dec_f = F_XOR;  dec_a = rs_val; dec_b = zx; end
            6'h0F:        begin dec_f = F_SLL;  dec_a = zx;     dec_b = XLEN'(LUI_SHIFT); end
            6'h23, 6'h2B: begin dec_f = F_ADD;  dec_a = rs_val; dec_b = sx; end
            6'h04:        begin dec_f = F_EQ;   dec_a = rs_val; dec_b = rt_val; end
            6'h05:        begin dec_f = F_EQ;   dec_a = rs_val; dec_b = rt_val; dec_br_neg = 1'b1; end
            default:      dec_illegal = 1'b1;
        endcase
    end

    logic            valid_q;
    logic [11:0]     f_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic            br_neg_q;
    logic            illegal_q;
    logic            accept;

    assign bus.id_ready = ~bus.flush & (~valid_q | bus.ex_ready);
    assign accept       = bus.id_valid & bus.id_ready;

    // Flush kills the held instruction but leaves a/b as they were; with f=0 they are don't-care.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            valid_q   <= 1'b0;
            f_q       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            br_neg_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else if (bus.flush) begin
            valid_q   <= 1'b0;
            f_q       <= '0;
            br_neg_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else if (accept) begin
            valid_q   <= 1'b1;
            f_q       <= dec_f;
            a_q       <= dec_a;
            b_q       <= dec_b;
            br_neg_q  <= dec_br_neg;
            illegal_q <= dec_illegal;
        end else if (bus.ex_ready) begin
            valid_q   <= 1'b0;
        end
    end

    assign bus.ex_valid   = valid_q;
    assign bus.ex_alu_f   = f_q;
    assign bus.ex_alu_a   = a_q;
    assign bus.ex_alu_b   = b_q;
    assign bus.ex_br_neg  = br_neg_q;
    assign bus.ex_illegal = illegal_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: reset, decode vectors, stall, flush and illegal encodings,
// each with hand-computed expected values.
module tb_alu_issue_stage;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    alu_issue_stage_if #(.XLEN(32)) bus ();

    alu_issue_stage #(.XLEN(32), .LUI_SHIFT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] sh,
                                           input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] opc, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] im);
        return {opc, rs, rt, im};
    endfunction

    task automatic expect_ex(input string tag, input logic v, input logic [11:0] f,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic bn, input logic ill);
        check({tag, ".valid"},   32'(bus.ex_valid),   32'(v));
        check({tag, ".f"},       32'(bus.ex_alu_f),   32'(f));
        check({tag, ".a"},       bus.ex_alu_a,        a);
        check({tag, ".b"},       bus.ex_alu_b,        b);
        check({tag, ".br_neg"},  32'(bus.ex_br_neg),  32'(bn));
        check({tag, ".illegal"}, 32'(bus.ex_illegal), 32'(ill));
    endtask

    initial begin
        // Reset held two cycles while ID offers addi rs=5 imm=FFFF.
        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.ex_ready  = 1'b1;
        bus.id_valid  = 1'b1;
        bus.id_instr  = i_type(6'h08, 5'd1, 5'd2, 16'hFFFF);
        bus.id_rs_val = 32'd5;
        bus.id_rt_val = 32'hDEAD_BEEF;
        tick();
        tick();
        rst = 1'b0;
        expect_ex("reset", 1'b0, 12'h000, 32'h0, 32'h0, 1'b0, 1'b0);

        tick();
        expect_ex("addi", 1'b1, 12'h001, 32'd5, 32'hFFFF_FFFF, 1'b0, 1'b0);

        bus.id_instr  = r_type(5'd9, 5'd2, 5'd3, 5'd4, 6'h03);
        bus.id_rs_val = 32'h1111_1111;
        bus.id_rt_val = 32'h8000_0000;
        tick();
        expect_ex("sra", 1'b1, 12'h400, 32'h8000_0000, 32'd4, 1'b0, 1'b0);

        bus.id_instr  = i_type(6'h0C, 5'd1, 5'd2, 16'h8000);
        bus.id_rs_val = 32'h0000_F0F0;
        tick();
        expect_ex("andi", 1'b1, 12'h010, 32'h0000_F0F0, 32'h0000_8000, 1'b0, 1'b0);

        bus.id_instr = i_type(6'h0F, 5'd0, 5'd2, 16'h1234);
        tick();
        expect_ex("lui", 1'b1, 12'h100, 32'h0000_1234, 32'd16, 1'b0, 1'b0);

        bus.id_instr  = i_type(6'h05, 5'd3, 5'd4, 16'h0010);
        bus.id_rs_val = 32'd7;
        bus.id_rt_val = 32'd7;
        tick();
        expect_ex("bne", 1'b1, 12'h800, 32'd7, 32'd7, 1'b1, 1'b0);

        bus.id_instr  = i_type(6'h0B, 5'd3, 5'd4, 16'h8000);
        bus.id_rs_val = 32'h0000_0042;
        tick();
        expect_ex("sltiu", 1'b1, 12'h008, 32'h0000_0042, 32'hFFFF_8000, 1'b0, 1'b0);

        bus.id_instr  = r_type(5'd5, 5'd6, 5'd7, 5'd0, 6'h06);
        bus.id_rs_val = 32'd3;
        bus.id_rt_val = 32'hF000_000F;
        tick();
        expect_ex("srlv", 1'b1, 12'h200, 32'hF000_000F, 32'd3, 1'b0, 1'b0);

        // Stall: EX not ready while a sub is offered; outputs hold the srlv.
        bus.ex_ready  = 1'b0;
        bus.id_instr  = r_type(5'd1, 5'd2, 5'd3, 5'd0, 6'h22);
        bus.id_rs_val = 32'd10;
        bus.id_rt_val = 32'd3;
        #1;
        check("stall.id_ready", 32'(bus.id_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_ex("stall", 1'b1, 12'h200, 32'hF000_000F, 32'd3, 1'b0, 1'b0);
            check("stall.id_ready_hold", 32'(bus.id_ready), 32'd0);
        end
        bus.ex_ready = 1'b1;
        #1;
        check("release.id_ready", 32'(bus.id_ready), 32'd1);
        tick();
        expect_ex("release_sub", 1'b1, 12'h002, 32'd10, 32'd3, 1'b0, 1'b0);
        bus.id_valid = 1'b0;
        tick();
        expect_ex("drain", 1'b0, 12'h002, 32'd10, 32'd3, 1'b0, 1'b0);

        // Flush: load a bne, then flush with a new xor offered and EX stalled.
        bus.id_valid  = 1'b1;
        bus.id_instr  = i_type(6'h05, 5'd1, 5'd2, 16'h0004);
        bus.id_rs_val = 32'd1;
        bus.id_rt_val = 32'd2;
        tick();
        expect_ex("bne2", 1'b1, 12'h800, 32'd1, 32'd2, 1'b1, 1'b0);
        bus.ex_ready = 1'b0;
        bus.flush    = 1'b1;
        bus.id_instr = r_type(5'd1, 5'd2, 5'd3, 5'd0, 6'h26);
        #1;
        check("flush.id_ready", 32'(bus.id_ready), 32'd0);
        tick();
        check("flush.valid",   32'(bus.ex_valid),   32'd0);
        check("flush.f",       32'(bus.ex_alu_f),   32'd0);
        check("flush.br_neg",  32'(bus.ex_br_neg),  32'd0);
        check("flush.illegal", 32'(bus.ex_illegal), 32'd0);

        // Illegal funct and illegal opcode still pass through with ex_valid=1.
        bus.flush    = 1'b0;
        bus.ex_ready = 1'b1;
        bus.id_instr = r_type(5'd1, 5'd2, 5'd3, 5'd0, 6'h3F);
        tick();
        expect_ex("bad_funct", 1'b1, 12'h000, 32'h0, 32'h0, 1'b0, 1'b1);
        bus.id_instr = i_type(6'h3F, 5'd1, 5'd2, 16'h1234);
        tick();
        expect_ex("bad_op", 1'b1, 12'h000, 32'h0, 32'h0, 1'b0, 1'b1);
        bus.id_instr = r_type(5'd1, 5'd2, 5'd3, 5'd0, 6'h27);
        bus.id_rs_val = 32'h0F0F_0000;
        bus.id_rt_val = 32'h0000_00FF;
        tick();
        expect_ex("nor", 1'b1, 12'h040, 32'h0F0F_0000, 32'h0000_00FF, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
